// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//
// Purpose:
//   Shares the single register-file write port between NUM_REQ producers (ALU result,
//   mux path, memory-load return, ...). Arbitration is round-robin with a valid/ready
//   handshake. A requester can hold its grant over a multi-word burst by asserting its
//   lock bit, for at most LOCK_MAX consecutive grants. The write port is driven from
//   registers, so a handshake at edge t produces the write during cycle t+1.
//
// Configuration:
//   REGFILE_WR_R0_DISCARD_EN  when defined, a handshake that targets register 0 completes
//                             normally (ready, pointer and FSM update) but does not raise
//                             the write enable, because register 0 is hard-wired to zero.
//                             When undefined, register 0 is written like any other.
//
// Ports:
//   CLK_I           in   clock, all state updates on the rising edge
//   RST_I           in   synchronous reset, active-high; also gates REQ_READY_O to 0
//   EN_I            in   global enable; 0 stalls arbitration and holds all state
//   REQ_VALID_I     in   per-requester write request
//   REQ_LOCK_I      in   per-requester "keep my grant for the next beat"
//   REQ_ADDR_I      in   flattened addresses, requester i at [i*AW +: AW]
//   REQ_DATA_I      in   flattened data, requester i at [i*DW +: DW]
//   REQ_READY_O     out  one-hot grant (combinational); handshake = VALID & READY
//   WR_PORT_EN_O    out  register-file write enable (single-cycle pulse per beat)
//   WR_PORT_ADDR_O  out  register-file write address
//   WR_PORT_DATA_O  out  register-file write data
//   LOCKED_O        out  arbiter is holding the grant for a burst owner
//   OWNER_O         out  index of the current / most recently granted requester

module regfile_wr_arbiter #(
    parameter int unsigned NUM_REQ            = 3,
    parameter int unsigned REGFILE_ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned LOCK_MAX           = 8,
    parameter int unsigned LOCK_CNT_WIDTH     = 4,
    localparam int unsigned OWNER_WIDTH       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                  CLK_I,
    input  logic                                  RST_I,
    input  logic                                  EN_I,
    input  logic [NUM_REQ-1:0]                    REQ_VALID_I,
    input  logic [NUM_REQ-1:0]                    REQ_LOCK_I,
    input  logic [NUM_REQ*REGFILE_ADDR_WIDTH-1:0] REQ_ADDR_I,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]         REQ_DATA_I,
    output logic [NUM_REQ-1:0]                    REQ_READY_O,
    output logic                                  WR_PORT_EN_O,
    output logic [REGFILE_ADDR_WIDTH-1:0]         WR_PORT_ADDR_O,
    output logic [DATA_WIDTH-1:0]                 WR_PORT_DATA_O,
    output logic                                  LOCKED_O,
    output logic [OWNER_WIDTH-1:0]                OWNER_O
);

    typedef enum logic [0:0] {
        StArb,
        StLocked
    } state_e;

    localparam logic [LOCK_CNT_WIDTH:0] LockMaxC = (LOCK_CNT_WIDTH + 1)'(LOCK_MAX);

    // State
    state_e                          state_q, state_d;
    logic [OWNER_WIDTH-1:0]          rr_ptr_q, rr_ptr_d;
    logic [OWNER_WIDTH-1:0]          owner_q, owner_d;
    logic [LOCK_CNT_WIDTH-1:0]       lock_cnt_q, lock_cnt_d;
    logic                            wr_en_q, wr_en_d;
    logic [REGFILE_ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]           wr_data_q, wr_data_d;

    // Arbitration results
    logic [NUM_REQ-1:0]              grant;
    logic [OWNER_WIDTH-1:0]          grant_idx;
    logic                            found;
    logic [REGFILE_ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]           sel_data;
    logic [LOCK_CNT_WIDTH:0]         lock_cnt_inc;

    // (base + off) mod NUM_REQ, valid for base < NUM_REQ and off <= NUM_REQ.
    function automatic logic [OWNER_WIDTH-1:0] wrap_add(input logic [OWNER_WIDTH-1:0] base,
                                                        input int unsigned            off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return sum[OWNER_WIDTH-1:0];
    endfunction

    // Grant selection. Reset and the global enable gate every grant, so nothing
    // downstream has to qualify REQ_READY_O.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        if (!RST_I && EN_I) begin
            if (state_q == StLocked) begin
                // Burst owner only; an idle owner still blocks everyone else.
                if (REQ_VALID_I[owner_q]) begin
                    grant_idx = owner_q;
                    found     = 1'b1;
                end
            end else begin
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    if (!found && REQ_VALID_I[wrap_add(rr_ptr_q, k)]) begin
                        grant_idx = wrap_add(rr_ptr_q, k);
                        found     = 1'b1;
                    end
                end
            end
            if (found) begin
                grant[grant_idx] = 1'b1;
            end
        end
    end

    // Payload of the granted requester.
    always_comb begin
        sel_addr = REQ_ADDR_I[32'(grant_idx) * REGFILE_ADDR_WIDTH +: REGFILE_ADDR_WIDTH];
        sel_data = REQ_DATA_I[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
    end

    assign lock_cnt_inc = {1'b0, lock_cnt_q} + 1'b1;

    // Next-state logic. A grant always completes a handshake because a grant is only
    // issued to a requester that is currently valid.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (found) begin
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
`ifdef REGFILE_WR_R0_DISCARD_EN
            // Register 0 reads as zero; the beat is consumed but not written.
            wr_en_d   = (sel_addr != '0);
`else
            wr_en_d   = 1'b1;
`endif
            // Pointer moves past the winner even inside a burst, so a forced
            // release hands the port to the next requester in line.
            rr_ptr_d  = wrap_add(grant_idx, 1);
            owner_d   = grant_idx;

            case (state_q)
                StArb: begin
                    if (REQ_LOCK_I[grant_idx] && (LOCK_MAX > 1)) begin
                        state_d    = StLocked;
                        lock_cnt_d = LOCK_CNT_WIDTH'(1);
                    end
                end
                StLocked: begin
                    if (!REQ_LOCK_I[grant_idx]) begin
                        state_d    = StArb;
                        lock_cnt_d = '0;
                    end else if (lock_cnt_inc >= LockMaxC) begin
                        state_d    = StArb;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_inc[LOCK_CNT_WIDTH-1:0];
                    end
                end
                default: begin
                    state_d = StArb;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q    <= StArb;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign REQ_READY_O    = grant;
    assign WR_PORT_EN_O   = wr_en_q;
    assign WR_PORT_ADDR_O = wr_addr_q;
    assign WR_PORT_DATA_O = wr_data_q;
    assign LOCKED_O       = (state_q == StLocked);
    assign OWNER_O        = owner_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios followed by random
// traffic, all compared against a behavioural model of the arbitration rules.

module tb_regfile_wr_arbiter;

    localparam int N  = 3;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int LM = 8;

`ifdef REGFILE_WR_R0_DISCARD_EN
    localparam bit Discard = 1'b1;
`else
    localparam bit Discard = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [N-1:0]    valid;
    logic [N-1:0]    lock;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] data;
    logic [N-1:0]    ready;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            locked;
    logic [1:0]      owner;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int            m_ptr;
    int            m_owner;
    int            m_beats;
    bit            m_locked;
    bit            m_wr_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(
        .NUM_REQ           (N),
        .REGFILE_ADDR_WIDTH(AW),
        .DATA_WIDTH        (DW),
        .LOCK_MAX          (LM),
        .LOCK_CNT_WIDTH    (4)
    ) dut (
        .CLK_I         (clk),
        .RST_I         (rst),
        .EN_I          (en),
        .REQ_VALID_I   (valid),
        .REQ_LOCK_I    (lock),
        .REQ_ADDR_I    (addr),
        .REQ_DATA_I    (data),
        .REQ_READY_O   (ready),
        .WR_PORT_EN_O  (wr_en),
        .WR_PORT_ADDR_O(wr_addr),
        .WR_PORT_DATA_O(wr_data),
        .LOCKED_O      (locked),
        .OWNER_O       (owner)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Which requester should win this cycle, or -1 for nobody.
    function automatic int model_grant();
        if (rst || !en) return -1;
        if (m_locked) return valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (valid[i]) return i;
        end
        return -1;
    endfunction

    // One clock cycle: inputs already driven; check ready, clock, check write port.
    task automatic cycle();
        int            g;
        logic [N-1:0]  exp_ready;
        logic [AW-1:0] a;
        #1;
        g = model_grant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("ready", 64'(ready), 64'(exp_ready));
        @(posedge clk);
        #1;
        if (rst) begin
            m_ptr = 0; m_owner = 0; m_beats = 0; m_locked = 0;
            m_wr_en = 0; m_addr = '0; m_data = '0;
        end else if (g >= 0) begin
            a       = addr[g*AW +: AW];
            m_addr  = a;
            m_data  = data[g*DW +: DW];
            m_wr_en = !(Discard && a == '0);
            m_ptr   = (g + 1) % N;
            m_owner = g;
            if (!m_locked) begin
                if (lock[g] && LM > 1) begin
                    m_locked = 1;
                    m_beats  = 1;
                end
            end else if (!lock[g]) begin
                m_locked = 0;
            end else begin
                m_beats++;
                if (m_beats >= LM) m_locked = 0;
            end
        end else begin
            m_wr_en = 0;
        end
        check("wr_en", 64'(wr_en), 64'(m_wr_en));
        check("wr_addr", 64'(wr_addr), 64'(m_addr));
        check("wr_data", 64'(wr_data), 64'(m_data));
        check("locked", 64'(locked), 64'(m_locked));
        check("owner", 64'(owner), 64'(m_owner));
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr[i*AW +: AW] = a;
        data[i*DW +: DW] = d;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; valid = '1; lock = '0; addr = '0; data = '0;
        for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), 32'h1000 + i);

        // Reset with all requesters valid
        repeat (2) cycle();

        // Round robin, no lock
        rst = 1'b0;
        repeat (6) cycle();

        // Single write from req1
        valid = 3'b010;
        set_req(1, 4'd5, 32'hDEADBEEF);
        cycle();
        valid = '0;
        cycle();

        // Burst: req2 locked against req0
        valid = 3'b101; lock = 3'b100;
        set_req(0, 4'd3, 32'h0000_AAAA);
        set_req(2, 4'd9, 32'h0000_2222);
        repeat (10) cycle();
        valid = '0; lock = '0;
        cycle();

        // Locked owner idles, then global stall, then release
        valid = 3'b001; lock = 3'b001;
        cycle();
        valid = 3'b010; lock = '0;
        repeat (3) cycle();
        en = 1'b0; valid = 3'b011;
        repeat (2) cycle();
        en = 1'b1;
        repeat (3) cycle();
        valid = '0;
        cycle();

        // Register-0 write
        valid = 3'b001;
        set_req(0, 4'd0, 32'd7);
        cycle();
        valid = '0;
        cycle();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 199) == 0);
            en    = ($urandom_range(0, 9) != 0);
            valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                lock[i] = ($urandom_range(0, 9) < 7);
                set_req(i, AW'($urandom), $urandom);
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
